// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read bus between the sysid checker (master) and the sysid control slave.
interface niosii_system_sysid_checker_if;
  logic        master_address;
  logic        master_read;
  logic        master_waitrequest;
  logic        master_readdatavalid;
  logic [31:0] master_readdata;

  modport master (
    output master_address,
    output master_read,
    input  master_waitrequest,
    input  master_readdatavalid,
    input  master_readdata
  );

  modport slave (
    input  master_address,
    input  master_read,
    output master_waitrequest,
    output master_readdatavalid,
    output master_readdata
  );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// Reads the sysid ID and timestamp words and compares them against build-time values,
// flagging an image/software mismatch in hardware before software runs.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1490989165,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                start,
  niosii_system_sysid_checker_if.master       bus,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic                                id_mismatch,
  output logic                                ts_mismatch,
  output logic                                timeout,
  output logic [31:0]                         id_value,
  output logic [31:0]                         ts_value
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID_CMD  = 3'd1;
  localparam logic [2:0] S_ID_WAIT = 3'd2;
  localparam logic [2:0] S_TS_CMD  = 3'd3;
  localparam logic [2:0] S_TS_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_auto, w_auto;
  logic             r_read, w_read;
  logic             r_addr, w_addr;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic             r_id_mm, w_id_mm;
  logic             r_ts_mm, w_ts_mm;
  logic             r_to, w_to;
  logic [31:0]      r_id_val, w_id_val;
  logic [31:0]      r_ts_val, w_ts_val;
  logic             w_expired;

  // State and all outputs are registered; the comb block below computes next values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_auto   <= AUTO_START;
      r_read   <= 1'b0;
      r_addr   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_id_mm  <= 1'b0;
      r_ts_mm  <= 1'b0;
      r_to     <= 1'b0;
      r_id_val <= '0;
      r_ts_val <= '0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_auto   <= w_auto;
      r_read   <= w_read;
      r_addr   <= w_addr;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_pass   <= w_pass;
      r_id_mm  <= w_id_mm;
      r_ts_mm  <= w_ts_mm;
      r_to     <= w_to;
      r_id_val <= w_id_val;
      r_ts_val <= w_ts_val;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_auto    = 1'b0;
    w_read    = r_read;
    w_addr    = r_addr;
    w_busy    = r_busy;
    w_done    = r_done;
    w_pass    = r_pass;
    w_id_mm   = r_id_mm;
    w_ts_mm   = r_ts_mm;
    w_to      = r_to;
    w_id_val  = r_id_val;
    w_ts_val  = r_ts_val;
    w_expired = (r_cnt >= CNT_LAST);

    case (r_state)
      S_IDLE, S_DONE: begin
        // Auto-start applies only to the first IDLE cycle after reset.
        if (start || ((r_state == S_IDLE) && r_auto)) begin
          w_state  = S_ID_CMD;
          w_cnt    = '0;
          w_read   = 1'b1;
          w_addr   = 1'b0;
          w_busy   = 1'b1;
          w_done   = 1'b0;
          w_pass   = 1'b0;
          w_id_mm  = 1'b0;
          w_ts_mm  = 1'b0;
          w_to     = 1'b0;
          w_id_val = '0;
          w_ts_val = '0;
        end
      end
      S_ID_CMD, S_TS_CMD: begin
        w_cnt = r_cnt + CNT_W'(1);
        if (!bus.master_waitrequest) begin
          w_read  = 1'b0;
          w_state = (r_state == S_ID_CMD) ? S_ID_WAIT : S_TS_WAIT;
        end else if (w_expired) begin
          w_read  = 1'b0;
          w_to    = 1'b1;
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = 1'b0;
        end
      end
      S_ID_WAIT, S_TS_WAIT: begin
        w_cnt = r_cnt + CNT_W'(1);
        // A response arriving on the last allowed cycle still counts as success.
        if (bus.master_readdatavalid) begin
          if (r_state == S_ID_WAIT) begin
            w_id_val = bus.master_readdata;
            w_id_mm  = (bus.master_readdata != EXPECTED_ID);
            w_state  = S_TS_CMD;
            w_cnt    = '0;
            w_read   = 1'b1;
            w_addr   = 1'b1;
          end else begin
            w_ts_val = bus.master_readdata;
            w_ts_mm  = CHECK_TIMESTAMP && (bus.master_readdata != EXPECTED_TIMESTAMP);
            w_state  = S_DONE;
            w_busy   = 1'b0;
            w_done   = 1'b1;
            w_pass   = !(r_id_mm | w_ts_mm | r_to);
          end
        end else if (w_expired) begin
          w_to    = 1'b1;
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_pass  = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_read  = 1'b0;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign bus.master_read    = r_read;
  assign bus.master_address = r_addr;
  assign busy               = r_busy;
  assign done               = r_done;
  assign pass               = r_pass;
  assign id_mismatch        = r_id_mm;
  assign ts_mismatch        = r_ts_mm;
  assign timeout            = r_to;
  assign id_value           = r_id_val;
  assign ts_value           = r_ts_val;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench: two checker instances (default and timestamp-unchecked/short-timeout)
// each attached to a small sysid slave model driven on the falling clock edge.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'd1490989165;
  localparam logic [31:0] TS_BAD  = 32'd1490989166;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, start0, start1;
  logic busy0, done0, pass0, idm0, tsm0, to0;
  logic busy1, done1, pass1, idm1, tsm1, to1;
  logic [31:0] idv0, tsv0, idv1, tsv1;

  niosii_system_sysid_checker_if bus0 ();
  niosii_system_sysid_checker_if bus1 ();

  niosii_system_sysid_checker u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .id_mismatch(idm0), .ts_mismatch(tsm0),
    .timeout(to0), .id_value(idv0), .ts_value(tsv0)
  );

  niosii_system_sysid_checker #(
    .CHECK_TIMESTAMP(1'b0), .AUTO_START(1'b0), .TIMEOUT_CYCLES(10)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .id_mismatch(idm1), .ts_mismatch(tsm1),
    .timeout(to1), .id_value(idv1), .ts_value(tsv1)
  );

  // Test-controlled model knobs
  logic [31:0] id0, ts0, id1, ts1;
  int          wreq0, wreq1;
  bit          drop0, drop1, force0;

  // Model-owned state
  int  cw0 = 0, cw1 = 0, tsr0 = 0, tsr1 = 0;
  bit  pend0 = 1'b0, pend1 = 1'b0, paddr0 = 1'b0, paddr1 = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always @(negedge clock) begin
    bus0.master_readdatavalid = 1'b0;
    if (pend0) begin
      bus0.master_readdatavalid = !drop0;
      bus0.master_readdata      = paddr0 ? ts0 : id0;
      pend0 = 1'b0;
    end
    if (force0) begin
      bus0.master_readdatavalid = 1'b1;
      bus0.master_readdata      = 32'hDEAD_BEEF;
    end
    if (bus0.master_read === 1'b1) begin
      if (bus0.master_address) tsr0++;
      if (cw0 < wreq0) begin
        bus0.master_waitrequest = 1'b1;
        cw0++;
      end else begin
        bus0.master_waitrequest = 1'b0;
        pend0  = 1'b1;
        paddr0 = bus0.master_address;
      end
    end else begin
      bus0.master_waitrequest = 1'b0;
      cw0 = 0;
    end
  end

  always @(negedge clock) begin
    bus1.master_readdatavalid = 1'b0;
    if (pend1) begin
      bus1.master_readdatavalid = !drop1;
      bus1.master_readdata      = paddr1 ? ts1 : id1;
      pend1 = 1'b0;
    end
    if (bus1.master_read === 1'b1) begin
      if (bus1.master_address) tsr1++;
      if (cw1 < wreq1) begin
        bus1.master_waitrequest = 1'b1;
        cw1++;
      end else begin
        bus1.master_waitrequest = 1'b0;
        pend1  = 1'b1;
        paddr1 = bus1.master_address;
      end
    end else begin
      bus1.master_waitrequest = 1'b0;
      cw1 = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive start so it is sampled at the next rising edge (edge 0), return 1ns after it.
  task automatic pulse(input int which);
    @(negedge clock);
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    int base;
    reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    id0 = 32'd0; ts0 = TS_GOOD; id1 = 32'd0; ts1 = TS_BAD;
    wreq0 = 0; wreq1 = 0; drop0 = 1'b0; drop1 = 1'b0; force0 = 1'b0;

    // Reset state
    step(3);
    chk("rst0_flags", 32'({busy0, done0, pass0, idm0, tsm0, to0, bus0.master_read, bus0.master_address}), 32'd0);
    chk("rst0_vals", idv0 | tsv0, 32'd0);
    chk("rst1_flags", 32'({busy1, done1, pass1, idm1, tsm1, to1, bus1.master_read, bus1.master_address}), 32'd0);

    // Auto start after reset release, nominal sysid
    @(negedge clock); reset_n = 1'b1;
    step(1);
    chk("auto_busy", 32'({busy0, bus0.master_read, bus0.master_address}), 32'b110);
    chk("noauto_busy1", 32'(busy1), 32'd0);
    step(3);
    chk("auto_done_e3", 32'(done0), 32'd0);
    step(1);
    chk("auto_done_pass", 32'({done0, pass0, busy0}), 32'b110);
    chk("auto_idv", idv0, 32'd0);
    chk("auto_tsv", tsv0, TS_GOOD);

    // Timestamp mismatch, checked
    ts0 = TS_BAD;
    pulse(0);
    chk("rerun_clr", 32'({done0, busy0}), 32'b01);
    step(4);
    chk("tsbad_flags", 32'({done0, pass0, idm0, tsm0, to0}), 32'b10010);
    chk("tsbad_tsv", tsv0, TS_BAD);

    // Timestamp mismatch, not checked
    pulse(1);
    step(4);
    chk("tsnochk_flags", 32'({done1, pass1, idm1, tsm1, to1}), 32'b11000);
    chk("tsnochk_tsv", tsv1, TS_BAD);

    // Three waitrequest cycles on the ID command
    ts0 = TS_GOOD;
    wreq0 = 3;
    pulse(0);
    chk("wr_clr", 32'({tsm0, done0}), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("wr_hold", 32'({bus0.master_read, bus0.master_address, bus0.master_waitrequest}), 32'b101);
    end
    wreq0 = 0;
    step(3);
    chk("wr_done_e6", 32'(done0), 32'd0);
    step(1);
    chk("wr_done_e7", 32'({done0, pass0}), 32'b11);

    // Missing ID response, 10-cycle timeout
    drop1 = 1'b1;
    base  = tsr1;
    pulse(1);
    step(9);
    chk("to_before", 32'({to1, busy1}), 32'b01);
    step(1);
    chk("to_flags", 32'({to1, done1, pass1, busy1, bus1.master_read}), 32'b11000);
    chk("to_vals", idv1 | tsv1, 32'd0);
    step(3);
    chk("to_no_ts_read", 32'(tsr1 - base), 32'd0);
    drop1 = 1'b0;

    // start while busy is ignored
    pulse(0);
    step(1);
    @(negedge clock); start0 = 1'b1;
    @(posedge clock); #1; start0 = 1'b0;
    step(1);
    chk("busy_start_e3", 32'(done0), 32'd0);
    step(1);
    chk("busy_start_done", 32'({done0, pass0, busy0}), 32'b110);
    chk("busy_start_tsv", tsv0, TS_GOOD);

    // Reset during ID_WAIT, stray readdatavalid afterwards
    drop0 = 1'b1;
    pulse(0);
    step(1);
    @(negedge clock); reset_n = 1'b0;
    step(1);
    chk("midrst_flags", 32'({busy0, done0, pass0, idm0, tsm0, to0, bus0.master_read, bus0.master_address}), 32'd0);
    chk("midrst_vals", idv0 | tsv0, 32'd0);
    chk("midrst_dut1", 32'({done1, to1}) | idv1 | tsv1, 32'd0);
    drop0  = 1'b0;
    force0 = 1'b1;
    @(negedge clock); reset_n = 1'b1;
    step(1);
    chk("stray_idle", idv0, 32'd0);
    step(1);
    force0 = 1'b0;
    chk("stray_cmd", idv0, 32'd0);
    step(3);
    chk("postrst_done", 32'({done0, pass0}), 32'b11);
    chk("postrst_idv", idv0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
